cordic_iter_sequencer: RTL and testbench

- Control FSM for one CORDIC datapath lane; drives the 2-bit select of the downstream 3:1 operand mux and the load enable of the working register that captures the mux output.
- Sequences one computation: initial operand load (ch_0), ITER feedback iterations (ch_1), one final adjust pass (ch_2).
- Start/ready/ack handshake to the FPU interface; iteration index feeds shift-amount and arctan-ROM address logic.

---
 rtl/cordic_iter_sequencer_if.sv | 36 +++
 rtl/cordic_iter_sequencer.sv | 111 +++++++++++
 tb/tb_cordic_iter_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_sequencer_if.sv
// Handshake/control bundle between the CORDIC sequencer, the FPU front end and the lane datapath.
// abort_cordic exists only when CORDIC_ABORT_EN is defined.
interface cordic_iter_sequencer_if #(
  parameter int CW = 5
);
  logic          beg_cordic;
  logic          ack_cordic;
`ifdef CORDIC_ABORT_EN
  logic          abort_cordic;
`endif
  logic [1:0]    sel_mux;
  logic          load_reg;
  logic [CW-1:0] iter_idx;
  logic          busy;
  logic          ready_cordic;

`ifdef CORDIC_ABORT_EN
  modport master (
    output beg_cordic, ack_cordic, abort_cordic,
    input  sel_mux, load_reg, iter_idx, busy, ready_cordic
  );
  modport slave (
    input  beg_cordic, ack_cordic, abort_cordic,
    output sel_mux, load_reg, iter_idx, busy, ready_cordic
  );
`else
  modport master (
    output beg_cordic, ack_cordic,
    input  sel_mux, load_reg, iter_idx, busy, ready_cordic
  );
  modport slave (
    input  beg_cordic, ack_cordic,
    output sel_mux, load_reg, iter_idx, busy, ready_cordic
  );
`endif
endinterface

// File: rtl/cordic_iter_sequencer.sv
// CORDIC lane sequencer: LOAD, ITER iterations, ADJUST, then DONE holding ready until ack (ITER+3 cycles to ready).
// Outputs decode registered state only; CORDIC_ABORT_EN adds abort_cordic to cancel an operation in flight.
module cordic_iter_sequencer #(
  parameter int ITER = 16,
  parameter int CW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  cordic_iter_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ITERATE = 3'd2,
    ADJUST  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          abort;
  logic [1:0]    sel_mux;
  logic          load_reg;
  logic          busy;
  logic          ready_cordic;

`ifdef CORDIC_ABORT_EN
  assign abort = bus.abort_cordic;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.beg_cordic) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: state_nxt = ITERATE;
      ITERATE: begin
        if (cnt == LAST) state_nxt = ADJUST;
        else             cnt_nxt   = cnt + CW'(1);
      end
      ADJUST: state_nxt = DONE;
      DONE: begin
        // abort in DONE is just another way of accepting the result
        if (bus.ack_cordic || abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (abort && (state == LOAD || state == ITERATE || state == ADJUST)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    sel_mux      = 2'b00;
    load_reg     = 1'b0;
    busy         = 1'b0;
    ready_cordic = 1'b0;
    case (state)
      LOAD: begin
        load_reg = 1'b1;
        busy     = 1'b1;
      end
      ITERATE: begin
        sel_mux  = 2'b01;
        load_reg = 1'b1;
        busy     = 1'b1;
      end
      ADJUST: begin
        sel_mux  = 2'b10;
        load_reg = 1'b1;
        busy     = 1'b1;
      end
      DONE:    ready_cordic = 1'b1;
      default: sel_mux      = 2'b00;
    endcase
  end

  assign bus.sel_mux      = sel_mux;
  assign bus.load_reg     = load_reg;
  assign bus.busy         = busy;
  assign bus.ready_cordic = ready_cordic;
  assign bus.iter_idx     = cnt;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Directed bench for cordic_iter_sequencer: ITER=4 main instance plus an ITER=1 instance.
module tb_cordic_iter_sequencer;
  localparam int ITER = 4;
  localparam int CW   = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  cordic_iter_sequencer_if #(.CW(CW)) bus ();
  cordic_iter_sequencer_if #(.CW(CW)) bus1 ();

  cordic_iter_sequencer #(.ITER(ITER), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cordic_iter_sequencer #(.ITER(1), .CW(CW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.load_reg) pulses++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packed {sel_mux, load_reg, busy, ready_cordic, iter_idx}; idx masked when care=0
  task automatic chk_out(input string tag, input logic [1:0] sel, input logic ld, input logic bsy,
                         input logic rdy, input logic [CW-1:0] idx, input bit care);
    logic [CW+4:0] o, e;
    o = {bus.sel_mux, bus.load_reg, bus.busy, bus.ready_cordic, care ? bus.iter_idx : {CW{1'b0}}};
    e = {sel, ld, bsy, rdy, care ? idx : {CW{1'b0}}};
    chk(tag, 32'(o), 32'(e));
  endtask

  task automatic chk_out1(input string tag, input logic [1:0] sel, input logic ld, input logic bsy,
                          input logic rdy, input logic [CW-1:0] idx);
    logic [CW+4:0] o, e;
    o = {bus1.sel_mux, bus1.load_reg, bus1.busy, bus1.ready_cordic, bus1.iter_idx};
    e = {sel, ld, bsy, rdy, idx};
    chk(tag, 32'(o), 32'(e));
  endtask

  initial begin
    logic [1:0]    esel [0:5];
    logic [CW-1:0] eidx [0:5];
    esel = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    eidx = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd3};

    rst = 1'b0;
    bus.beg_cordic  = 1'b0;
    bus.ack_cordic  = 1'b0;
    bus1.beg_cordic = 1'b0;
    bus1.ack_cordic = 1'b0;
`ifdef CORDIC_ABORT_EN
    bus.abort_cordic  = 1'b0;
    bus1.abort_cordic = 1'b0;
`endif

    // reset held while beg toggles
    for (int i = 0; i < 3; i++) begin
      bus.beg_cordic = ~bus.beg_cordic;
      tick();
      chk_out($sformatf("reset_%0d", i), 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    bus.beg_cordic = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk_out("idle_after_reset", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // nominal op, ready held 10 cycles, ack in cycle 17
    pulses = 0;
    bus.beg_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk_out($sformatf("nom_c%0d", c + 1), esel[c], 1'b1, 1'b1, 1'b0, eidx[c], 1'b1);
      tick();
    end
    for (int c = 7; c < 17; c++) begin
      chk_out($sformatf("hold_c%0d", c), 2'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      tick();
    end
    bus.ack_cordic = 1'b1;
    chk_out("ack_c17", 2'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    tick();
    bus.ack_cordic = 1'b0;
    chk_out("idle_c18", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("nom_pulses", 32'(pulses), 32'(ITER + 2));

    // ack in IDLE does nothing
    bus.ack_cordic = 1'b1;
    tick();
    bus.ack_cordic = 1'b0;
    chk_out("ack_in_idle", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // stray beg during ITERATE, stray ack during ITERATE/ADJUST
    pulses = 0;
    bus.beg_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.beg_cordic = (c == 1 || c == 2);
      bus.ack_cordic = (c == 3 || c == 5);
      chk_out($sformatf("ign_c%0d", c + 1), esel[c], 1'b1, 1'b1, 1'b0, eidx[c], 1'b1);
      tick();
    end
    bus.beg_cordic = 1'b0;
    bus.ack_cordic = 1'b0;
    chk_out("ign_done_c7", 2'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("ign_pulses", 32'(pulses), 32'(ITER + 2));
    bus.beg_cordic = 1'b1;
    bus.ack_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    bus.ack_cordic = 1'b0;
    chk_out("begack_idle_c8", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    chk_out("begack_noload_c9", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // reset mid-operation at iter_idx=2
    bus.beg_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    tick();
    tick();
    tick();
    chk_out("midrst_pre", 2'd1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1);
    rst = 1'b0;
    #1;
    chk_out("midrst_async", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("midrst_idle_%0d", c), 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    pulses = 0;
    bus.beg_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk_out($sformatf("fresh_c%0d", c + 1), esel[c], 1'b1, 1'b1, 1'b0, eidx[c], 1'b1);
      tick();
    end
    chk_out("fresh_done", 2'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("fresh_pulses", 32'(pulses), 32'(ITER + 2));
    bus.ack_cordic = 1'b1;
    tick();
    bus.ack_cordic = 1'b0;
    chk_out("fresh_idle", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // ITER=1: single ITERATE cycle at index 0
    bus1.beg_cordic = 1'b1;
    tick();
    bus1.beg_cordic = 1'b0;
    chk_out1("it1_load", 2'd0, 1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    chk_out1("it1_iter", 2'd1, 1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    chk_out1("it1_adjust", 2'd2, 1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    chk("it1_ready", 32'(bus1.ready_cordic), 32'd1);
    chk("it1_noload", 32'(bus1.load_reg), 32'd0);
    bus1.ack_cordic = 1'b1;
    tick();
    bus1.ack_cordic = 1'b0;
    chk("it1_idle_ready", 32'(bus1.ready_cordic), 32'd0);

`ifdef CORDIC_ABORT_EN
    // abort at iter_idx=1
    bus.beg_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    tick();
    tick();
    chk_out("abort_pre", 2'd1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1);
    bus.abort_cordic = 1'b1;
    tick();
    bus.abort_cordic = 1'b0;
    chk_out("abort_idle", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("abort_noready_%0d", c), 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    // abort in DONE acts as ack
    bus.beg_cordic = 1'b1;
    tick();
    bus.beg_cordic = 1'b0;
    repeat (6) tick();
    chk_out("abort_done_pre", 2'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    bus.abort_cordic = 1'b1;
    tick();
    bus.abort_cordic = 1'b0;
    chk_out("abort_done_idle", 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
